// File: rtl/ans_pkg.sv
// Shared ANS definitions: table geometry defaults, FSM state encoding and the
// saturating-increment helper used by the encoder and the count loader.
package ans_pkg;

    localparam int SYM_WIDTH = 2;
    localparam int CNT_WIDTH = 8;
    localparam int SYM_COUNT = 1 << SYM_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        SEND     = 2'd2
    } state_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/ans_count_sender_histogram.sv
// Per-symbol saturating histogram: one increment port, a combinational read
// port and a synchronous clear (clear wins over increment).
module ans_histogram
    import ans_pkg::*;
#(
    parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH,
    parameter int CNT_WIDTH = ans_pkg::CNT_WIDTH,
    parameter int SYM_COUNT = 1 << SYM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_en,
    input  logic [SYM_WIDTH-1:0] inc_sym,
    input  logic                 clr,
    input  logic [SYM_WIDTH-1:0] rd_idx,
    output logic [CNT_WIDTH-1:0] rd_cnt
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    logic [CNT_WIDTH-1:0] counts [SYM_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYM_COUNT; i++) counts[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < SYM_COUNT; i++) counts[i] <= '0;
        end else if (inc_en) begin
            counts[inc_sym] <= CNT_WIDTH'(sat_inc(32'(counts[inc_sym]), CNT_MAX));
        end
    end

    assign rd_cnt = counts[rd_idx];

endmodule

// File: rtl/ans_count_sender.sv
// ANS count-table sender: histograms symbols while idle, then streams every
// count on start. Define ANS_HIST_AUTOCLR_EN to clear the table when done fires.
module ans_count_sender
    import ans_pkg::*;
#(
    parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH,
    parameter int SYM_COUNT = 1 << SYM_WIDTH,
    parameter int CNT_WIDTH = ans_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SYM_WIDTH-1:0] sym_in,
    input  logic                 sym_vld,
    output logic                 sym_rdy,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] out,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [1:0]           state_dbg
);

    // Handshake: a word moves on the edge where out_vld && out_rdy. out_vld is
    // only raised after out_rdy was sampled high in WAIT_RDY, and is dropped
    // on acceptance, so the return-to-zero receiver can never deadlock.
    localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(SYM_COUNT - 1);

    state_t               state, state_d;
    logic [SYM_WIDTH-1:0] idx, idx_d;
    logic [CNT_WIDTH-1:0] out_d;
    logic                 out_vld_d, busy_d, done_d;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic                 hist_clr;

    assign sym_rdy   = !busy;
    assign state_dbg = state;

`ifdef ANS_HIST_AUTOCLR_EN
    assign hist_clr = done_d;
`else
    assign hist_clr = 1'b0;
`endif

    ans_histogram #(
        .SYM_WIDTH(SYM_WIDTH),
        .CNT_WIDTH(CNT_WIDTH),
        .SYM_COUNT(SYM_COUNT)
    ) u_hist (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (sym_vld && sym_rdy),
        .inc_sym(sym_in),
        .clr    (hist_clr),
        .rd_idx (idx),
        .rd_cnt (rd_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            out     <= '0;
            out_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            out     <= out_d;
            out_vld <= out_vld_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        out_d     = out;
        out_vld_d = out_vld;
        busy_d    = busy;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    out_vld_d = 1'b0;
                    state_d   = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                out_vld_d = 1'b0;
                if (out_rdy) begin
                    out_d     = rd_cnt;
                    out_vld_d = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (out_rdy) begin
                    out_vld_d = 1'b0;
                    if (idx == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + SYM_WIDTH'(1);
                        state_d = WAIT_RDY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ans_count_sender.sv
// Bench for ans_count_sender: symbol stimulus feeds a histogram model whose
// table is queued at start and checked word by word against a loader model.
module tb_ans_count_sender;
    import ans_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] sym_in;
    logic       sym_vld;
    logic       sym_rdy;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       out_vld;
    logic       out_rdy;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    int  model_cnt [4];
    int  hold;
    bit  pending;
    int  words_got;
    int  done_cycle;

    ans_count_sender dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sym_in   (sym_in),
        .sym_vld  (sym_vld),
        .sym_rdy  (sym_rdy),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n   = 1'b0;
        sym_in  = '0;
        sym_vld = 1'b0;
        start   = 1'b0;
        out_rdy = 1'b1;
        pending = 1'b0;
        hold    = 0;
        exp_q.delete();
        for (int s = 0; s < 4; s++) model_cnt[s] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_syms(input int n, input int fixed_sym);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sym_in  = (fixed_sym >= 0) ? 2'(fixed_sym) : 2'($urandom_range(0, 3));
            sym_vld = 1'b1;
            if (model_cnt[sym_in] < 255) model_cnt[sym_in]++;
        end
        @(negedge clk);
        sym_vld = 1'b0;
    endtask

    task automatic send_list(input int a, input int b, input int c, input int d);
        int lst [4];
        lst = '{a, b, c, d};
        for (int i = 0; i < 4; i++) send_syms(1, lst[i]);
    endtask

    // Starts a frame and plays the count loader until done, abort or timeout.
    task automatic run_frame(input int delay, input bit disturb, input int abort_after);
        int cyc;
        bit prev_vld, prev_rdy, finished, aborted;
        logic [7:0] prev_out, e;
        cyc = 0; words_got = 0; pending = 1'b0; finished = 1'b0; aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int s = 0; s < 4; s++) exp_q.push_back(8'(model_cnt[s]));
        prev_vld = out_vld; prev_rdy = out_rdy; prev_out = out;
        while (!finished && !aborted && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL busy_set: got %b expected 1", busy); end
            end
            if (!prev_vld && out_vld) begin
                total++;
                if (prev_rdy !== 1'b1) begin bad++; $display("FAIL vld_rise_rdy_low: rdy was %b expected 1", prev_rdy); end
            end
            if (prev_vld && out_vld) begin
                total++;
                if (out !== prev_out) begin bad++; $display("FAIL out_stable: got %0d expected %0d", out, prev_out); end
            end
            if (done === 1'b1) begin
                total++;
                if (words_got != 4 || exp_q.size() != 0) begin
                    bad++; $display("FAIL word_count: got %0d words expected 4 (left %0d)", words_got, exp_q.size());
                end
                done_cycle = cyc;
                finished = 1'b1;
`ifdef ANS_HIST_AUTOCLR_EN
                for (int s = 0; s < 4; s++) model_cnt[s] = 0;
`endif
            end else begin
                if (pending) begin
                    out_rdy = 1'b0; pending = 1'b0; hold = delay;
                end else if (out_vld && out_rdy) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++; $display("FAIL extra_word: got %0d expected none", out);
                    end else begin
                        e = exp_q.pop_front();
                        if (out !== e) begin bad++; $display("FAIL word%0d: got %0d expected %0d", words_got, out, e); end
                    end
                    pending = 1'b1;
                    words_got++;
                end else if (!out_rdy && !out_vld) begin
                    if (hold > 0) hold--; else out_rdy = 1'b1;
                end
                if (disturb) begin
                    if (words_got >= 1 && words_got < 3) begin
                        start = 1'b1; sym_vld = 1'b1; sym_in = 2'd0;
                        total++;
                        if (sym_rdy !== 1'b0) begin bad++; $display("FAIL sym_rdy_busy: got %b expected 0", sym_rdy); end
                    end else begin
                        start = 1'b0; sym_vld = 1'b0;
                    end
                end
                if (abort_after > 0 && words_got == abort_after && !pending) begin
                    rst_n = 1'b0;
                    #1;
                    total++;
                    if (out_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'(IDLE)) begin
                        bad++;
                        $display("FAIL abort_outputs: got vld=%b busy=%b done=%b st=%0d expected 0 0 0 0",
                                 out_vld, busy, done, state_dbg);
                    end
                    aborted = 1'b1;
                end
            end
            prev_vld = out_vld; prev_rdy = out_rdy; prev_out = out;
        end
        if (!finished && !aborted) begin
            total++; bad++;
            $display("FAIL frame_timeout: got %0d words expected 4", words_got);
        end
        if (finished) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            for (int s = 0; s < 4; s++) model_cnt[s] = 0;
        end
        start = 1'b0; sym_vld = 1'b0;
        out_rdy = 1'b1; pending = 1'b0; hold = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL rst_out_vld: got %b expected 0", out_vld); end
        total++; if (out !== 8'd0) begin bad++; $display("FAIL rst_out: got %0d expected 0", out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
        total++; if (sym_rdy !== 1'b1) begin bad++; $display("FAIL rst_sym_rdy: got %b expected 1", sym_rdy); end
        total++; if (state_dbg !== 2'(IDLE)) begin bad++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_basic_frame();
        do_reset();
        send_list(0, 1, 1, 3);
        run_frame(0, 1'b0, 0);
        total++;
        if (done_cycle != 12) begin bad++; $display("FAIL basic_latency: got %0d expected 12", done_cycle); end
    endtask

    task automatic test_autoclear();
        run_frame(0, 1'b0, 0);
    endtask

    task automatic test_saturation();
        do_reset();
        send_syms(300, 2);
        run_frame(0, 1'b0, 0);
    endtask

    task automatic test_slow_receiver();
        do_reset();
        send_syms(12, -1);
        run_frame(5, 1'b0, 0);
    endtask

    task automatic test_busy_protection();
        do_reset();
        send_syms(7, -1);
        run_frame(2, 1'b1, 0);
        run_frame(0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        send_list(2, 3, 3, 1);
        run_frame(0, 1'b0, 2);
        run_frame(0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_autoclear();
        test_saturation();
        test_slow_receiver();
        test_busy_protection();
        test_reset_mid_transfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
